ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the host to the attached keyboard over the same two open-drain lines that `ps2_keyboard` receives on. It performs the host request-to-send sequence, shifts out data, parity and stop bits on device-generated clock edges, and checks the device acknowledge bit. It sits beside `ps2_keyboard` in `top`, sharing the `ps2_clk` and `ps2_data` pads through open-drain enables.

## Interface
- `INHIBIT_CYCLES`, default 5000: clk cycles `ps2_clk` is held low before the start bit (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, default 1000000: maximum clk cycles allowed between consecutive device falling edges once the clock is released.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `tx_valid`  in  1  request to send `tx_data`.
- `tx_data`  in  8  command byte.
- `tx_ready`  out  1  high when idle and able to accept a byte.
- `ps2_clk_i`  in  1  raw `ps2_clk` pad level (asynchronous).
- `ps2_data_i`  in  1  raw `ps2_data` pad level (asynchronous).
- `ps2_clk_oe`  out  1  1 = drive `ps2_clk` pad low; 0 = release.
- `ps2_data_oe`  out  1  1 = drive `ps2_data` pad low; 0 = release.
- `done`  out  1  one-cycle pulse when a frame ends (acknowledged, NACKed or timed out).
- `ack_err`  out  1  valid with `done`: 1 = no ACK or timeout.

## Operation
- Accept when `tx_valid && tx_ready`; latch byte; compute odd parity (`~^tx_data`). `tx_valid` while busy is ignored; there is no queue.
- States:
  - IDLE: both lines released; `tx_ready`=1.
  - INHIBIT: `ps2_clk_oe`=1 for `INHIBIT_CYCLES` cycles.
  - REQ: `ps2_data_oe`=1 (start bit 0), `ps2_clk_oe`=0. The timeout counter starts here.
  - SHIFT: driven by device falling edges 1–10.
    - Edges 1–8: present data bits LSB first.
    - Edge 9: present the parity bit.
    - Edge 10: release data (stop bit = 1).
    - Bit value b is driven as `ps2_data_oe` = ~b.
  - ACK: on falling edge 11, sample `ps2_data_i`. 0 = ACK (`ack_err`=0), 1 = NACK (`ack_err`=1). Pulse `done` and go to IDLE.
- Timeout: in REQ/SHIFT/ACK, the counter reloads on every detected falling edge. If it reaches `TIMEOUT_CYCLES`, release both lines, pulse `done` with `ack_err`=1, and return to IDLE.
- 4-bit edge counter; 8-bit shift register; the inhibit and timeout counters are sized with `$clog2` of their parameters.

## Timing
- Reset values: `ps2_clk_oe`=0, `ps2_data_oe`=0, `done`=0, `ack_err`=0, `tx_ready`=1, state IDLE.
- Reset asserted mid-frame releases both lines immediately (asynchronous) and aborts without a `done`.
- Input path: 2-flop synchronizer plus a previous-value flop per line. A pad falling edge is seen as an internal edge strobe 3 clk cycles later.
- All outputs are registered. Each data-line change occurs 1 cycle after the edge strobe, which is well inside the device's clock-low half-period.
- Cycle counts:
  - Accept → `ps2_clk_oe`=1: next cycle.
  - Inhibit: exactly `INHIBIT_CYCLES` cycles.
  - `ps2_data_oe`=1 is asserted in the same cycle `ps2_clk_oe` drops.
- `done` and `ack_err` are valid in the same cycle. `tx_ready` returns high in the cycle after `done`.
- A falling edge and timeout expiry in the same cycle: the edge wins.

## Structure
- Shared package `ps2_pkg`:
  - `ps2_tx_state_t` enum.
  - Frame constants `PS2_DATA_BITS`=8, `PS2_EDGE_PARITY`=9, `PS2_EDGE_STOP`=10, `PS2_EDGE_ACK`=11.
- One sub-module `ps2_sync_edge`: synchronizer and falling-edge strobe, instantiated for both lines and reusable by `ps2_keyboard`.
- `top` ties pads as open-drain: pad = oe ? 0 : z, with pull-up.

## Test plan
- Send 0xED with the device model ACKing: drive sequence 1,0,1,1,0,1,1,1 then parity 1. Stop released at edge 10. Expect `done`=1, `ack_err`=0, and `ps2_clk_oe` high for exactly `INHIBIT_CYCLES` (set to 20).
- Send 0x01: expect parity bit 0. Send 0x00: expect parity bit 1. Both ACKed.
- Device model holds data high at edge 11 for 0xFF: expect `done`=1, `ack_err`=1.
- Device stops clocking after edge 4 with `TIMEOUT_CYCLES`=100: expect both oe=0, then `done`/`ack_err`=1 exactly 100 cycles after the last edge strobe.
- `tx_valid` with 0xAA held during a 0xED frame: expect only 0xED sent and `tx_ready`=0 until `done`+1.
- Assert `rst` at edge 5: expect both oe=0 asynchronously, no `done`, `tx_ready`=1; a following 0xF4 frame completes with ACK.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame edge numbering
// and the frame parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    PS2_TX_IDLE    = 3'd0,
    PS2_TX_INHIBIT = 3'd1,
    PS2_TX_REQ     = 3'd2,
    PS2_TX_SHIFT   = 3'd3,
    PS2_TX_ACK     = 3'd4
  } ps2_tx_state_t;

  // Device falling-edge numbers within a host-to-device frame.
  localparam logic [3:0] PS2_DATA_BITS   = 4'd8;
  localparam logic [3:0] PS2_EDGE_PARITY = 4'd9;
  localparam logic [3:0] PS2_EDGE_STOP   = 4'd10;
  localparam logic [3:0] PS2_EDGE_ACK    = 4'd11;

  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizes one asynchronous PS/2 pad and strobes its falling edges.
// Lines idle high, so the flops reset to 1 to avoid a false edge after reset.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pad_i,
  output logic level_o,
  output logic fall_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Two-flop synchronizer followed by a delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= pad_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign level_o = sync2_q;
  assign fall_o  = prev_q & ~sync2_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, bit shifting on device
// clock falls, acknowledge check and inter-edge timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       ack_err
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_t    state_q, state_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [3:0]       edge_q, edge_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             done_q, done_d;
  logic             ack_err_q, ack_err_d;
  logic             ready_q, ready_d;

  logic       clk_fall_s;
  logic       data_level_s;
  logic       clk_level_unused;
  logic       data_fall_unused;
  logic [3:0] edge_nxt_s;
  logic       tmo_expired_s;

  ps2_sync_edge u_clk_sync (
    .clk     (clk),
    .rst     (rst),
    .pad_i   (ps2_clk_i),
    .level_o (clk_level_unused),
    .fall_o  (clk_fall_s)
  );

  ps2_sync_edge u_data_sync (
    .clk     (clk),
    .rst     (rst),
    .pad_i   (ps2_data_i),
    .level_o (data_level_s),
    .fall_o  (data_fall_unused)
  );

  assign edge_nxt_s    = edge_q + 4'd1;
  assign tmo_expired_s = (tmo_q == TMO_LAST);

  // Next-state logic; a device edge always takes priority over timeout expiry.
  always_comb begin
    state_d   = state_q;
    inh_d     = inh_q;
    tmo_d     = tmo_q;
    edge_d    = edge_q;
    shift_d   = shift_q;
    par_d     = par_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    ack_err_d = ack_err_q;
    ready_d   = ready_q;
    case (state_q)
      PS2_TX_IDLE: begin
        if (tx_valid && ready_q) begin
          state_d  = PS2_TX_INHIBIT;
          shift_d  = tx_data;
          par_d    = ps2_odd_parity(tx_data);
          inh_d    = '0;
          clk_oe_d = 1'b1;
          ready_d  = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
      PS2_TX_INHIBIT: begin
        if (inh_q == INH_LAST) begin
          state_d   = PS2_TX_REQ;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          tmo_d     = '0;
          edge_d    = 4'd0;
        end else begin
          inh_d = inh_q + 1'b1;
        end
      end
      PS2_TX_REQ, PS2_TX_SHIFT: begin
        if (clk_fall_s) begin
          tmo_d   = '0;
          edge_d  = edge_nxt_s;
          state_d = PS2_TX_SHIFT;
          if (edge_nxt_s <= PS2_DATA_BITS) begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end else if (edge_nxt_s == PS2_EDGE_PARITY) begin
            data_oe_d = ~par_q;
          end else if (edge_nxt_s == PS2_EDGE_STOP) begin
            data_oe_d = 1'b0;
            state_d   = PS2_TX_ACK;
          end else begin
            state_d   = PS2_TX_IDLE;
            data_oe_d = 1'b0;
            done_d    = 1'b1;
            ack_err_d = 1'b1;
          end
        end else if (tmo_expired_s) begin
          state_d   = PS2_TX_IDLE;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          done_d    = 1'b1;
          ack_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      PS2_TX_ACK: begin
        if (clk_fall_s && (edge_nxt_s == PS2_EDGE_ACK)) begin
          state_d   = PS2_TX_IDLE;
          done_d    = 1'b1;
          ack_err_d = data_level_s;
        end else if (clk_fall_s || tmo_expired_s) begin
          state_d   = PS2_TX_IDLE;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          done_d    = 1'b1;
          ack_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d   = PS2_TX_IDLE;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset releases both lines immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PS2_TX_IDLE;
      inh_q     <= '0;
      tmo_q     <= '0;
      edge_q    <= 4'd0;
      shift_q   <= 8'd0;
      par_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      inh_q     <= inh_d;
      tmo_q     <= tmo_d;
      edge_q    <= edge_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      ack_err_q <= ack_err_d;
      ready_q   <= ready_d;
    end
  end

  assign tx_ready    = ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign ack_err     = ack_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a device model clocks frames in, while a
// monitor checks each done against the expected frame queued at request time.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, done, ack_err;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       clk_pad, data_pad;

  assign clk_pad  = dev_clk & ~ps2_clk_oe;
  assign data_pad = dev_data & ~ps2_data_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_i   (clk_pad),
    .ps2_data_i  (data_pad),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .done        (done),
    .ack_err     (ack_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       ack_err;
    logic       tmo;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
  } obs_t;

  exp_t exp_q[$];
  obs_t obs_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   last_fall_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: tracks tx_ready/inhibit expectations and scores every done.
  initial begin : monitor
    logic ready_prev, exp_ready, clk_oe_prev;
    int   run;
    exp_t e;
    obs_t o;
    ready_prev = 1'b1; exp_ready = 1'b1; clk_oe_prev = 1'b0; run = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        exp_q.delete(); obs_q.delete();
        ready_prev = 1'b1; exp_ready = 1'b1; clk_oe_prev = 1'b0; run = 0;
      end else begin
        if (tx_valid && ready_prev) begin
          exp_ready = 1'b0;
          chk("accept_clk_oe", 32'(ps2_clk_oe), 32'd1);
        end
        if (ps2_clk_oe) run++;
        else if (clk_oe_prev) begin
          chk("inhibit_len", 32'(run), 32'(INH));
          chk("start_bit_at_release", 32'(ps2_data_oe), 32'd1);
          run = 0;
        end
        clk_oe_prev = ps2_clk_oe;
        if (done) begin
          chk("done_lines_released", 32'({ps2_clk_oe, ps2_data_oe}), 32'd0);
          chk("done_pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ack_err", 32'(ack_err), 32'(e.ack_err));
            if (e.tmo) begin
              chk("timeout_latency", 32'(cyc - last_fall_cyc), 32'(TMO + 3));
            end else begin
              chk("frame_captured", 32'(obs_q.size() > 0), 32'd1);
              if (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                chk("data_byte", 32'(o.data), 32'(e.data));
                chk("parity_bit", 32'(o.par), 32'(e.par));
                chk("stop_bit", 32'(o.stop), 32'd1);
              end
            end
          end
        end
        chk("tx_ready", 32'(tx_ready), 32'(exp_ready));
        if (done) exp_ready = 1'b1;
        ready_prev = tx_ready;
      end
    end
  end

  // Device side: waits for request-to-send, then generates n_falls clock falls.
  task automatic device_frame(input int half, input bit nack, input int n_falls, input bit do_rst);
    logic [9:0] bits;
    int         w;
    obs_t       o;
    bits = '0;
    w = 0;
    while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && w < 400) begin
      @(negedge clk);
      w++;
    end
    chk("request_to_send_seen", 32'(w < 400), 32'd1);
    if (w >= 400) return;
    repeat (3) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      if (k > n_falls) return;
      if (k == 11 && !nack) dev_data = 1'b0;
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      if (do_rst && k == 5) begin
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_no_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        dev_clk = 1'b1;
        return;
      end
      repeat (half) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) bits[k-1] = data_pad;
      if (k == 10) begin
        o.data = bits[7:0];
        o.par  = bits[8];
        o.stop = bits[9];
        obs_q.push_back(o);
      end
      if (k == 11) dev_data = 1'b1;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (tx_ready !== 1'b1 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("idle_reached", 32'(tx_ready), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit nack, input int n_falls,
                      input int half, input bit hold, input bit do_rst);
    exp_t e;
    int   w;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    e.data    = b;
    e.par     = ($countones(b) % 2 == 0);
    e.tmo     = (n_falls < 11);
    e.ack_err = nack || e.tmo;
    if (!do_rst) exp_q.push_back(e);
    @(negedge clk);
    if (hold) tx_data = 8'hAA;
    else tx_valid = 1'b0;
    if (hold) begin
      fork
        device_frame(half, nack, n_falls, do_rst);
        begin
          w = 0;
          do begin
            @(posedge clk); #1;
            w++;
          end while (!done && w < 2000);
          chk("hold_done_seen", 32'(done), 32'd1);
          tx_valid = 1'b0;
        end
      join
    end else begin
      device_frame(half, nack, n_falls, do_rst);
    end
    wait_idle();
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    chk("reset_tx_ready", 32'(tx_ready), 32'd1);
    chk("reset_clk_oe", 32'(ps2_clk_oe), 32'd0);
    chk("reset_data_oe", 32'(ps2_data_oe), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ack_err", 32'(ack_err), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    send(8'hED, 1'b0, 11, 10, 1'b0, 1'b0);
    send(8'h01, 1'b0, 11, 8, 1'b0, 1'b0);
    send(8'h00, 1'b0, 11, 9, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 11, 10, 1'b0, 1'b0);
    send(8'h5A, 1'b0, 4, 10, 1'b0, 1'b0);
    send(8'hED, 1'b0, 11, 10, 1'b1, 1'b0);
    send(8'h3C, 1'b0, 11, 10, 1'b0, 1'b1);
    send(8'hF4, 1'b0, 11, 10, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0), 11,
           int'($urandom_range(6, 12)), 1'b0, 1'b0);
    end

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
